// File: rtl/wolfram_ca_engine.sv
// Programmable 1-D elementary cellular automaton: WIDTH cells, 8-bit rule, one generation per clock.
// Optional macro CA_FIXPOINT_EN adds a fixpoint output and early termination on a stable generation.
module wolfram_ca_engine #(
    parameter int         WIDTH        = 16,
    parameter int         CNT_W        = 16,
    parameter logic [7:0] DEFAULT_RULE = 8'h64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_rule,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [CNT_W-1:0] cfg_steps,
    input  logic             cfg_wrap,
    output logic [WIDTH-1:0] state_out,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
`ifdef CA_FIXPOINT_EN
    output logic             done,
    output logic             fixpoint
`else
    output logic             done
`endif
);

    // state | meaning
    // IDLE  | waiting for a config; holds last generation, cfg_ready high
    // RUN   | one generation computed per clock until step count is reached
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ca_state_t;

    ca_state_t        state_q, state_d;
    logic [WIDTH-1:0] gen_q, gen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] steps_q;
    logic [7:0]       rule_q;
    logic             wrap_q;
    logic             done_q, done_d;
    logic             load;

    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] next_gen;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_step;
    logic             stall;
    logic             finish;

    // ext[i+2:i] is {left, centre, right} for cell i; the end bits carry the boundary
    assign ext = {(wrap_q & gen_q[0]), gen_q, (wrap_q & gen_q[WIDTH-1])};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign next_gen[i] = rule_q[ext[i +: 3]];
    end

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_step = (cnt_inc == steps_q);

`ifdef CA_FIXPOINT_EN
    logic fix_q, fix_d;
    assign stall = (next_gen == gen_q);
`else
    assign stall = 1'b0;
`endif

    assign finish = last_step | stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
`ifdef CA_FIXPOINT_EN
        fix_d   = fix_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    load   = 1'b1;
                    gen_d  = cfg_seed;
                    cnt_d  = '0;
`ifdef CA_FIXPOINT_EN
                    fix_d  = 1'b0;
`endif
                    if (cfg_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                gen_d = next_gen;
                cnt_d = cnt_inc;
                if (finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef CA_FIXPOINT_EN
                    fix_d   = stall;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_q   <= '0;
            cnt_q   <= '0;
            steps_q <= '0;
            rule_q  <= DEFAULT_RULE;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            gen_q  <= gen_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            if (load) begin
                steps_q <= cfg_steps;
                rule_q  <= cfg_rule;
                wrap_q  <= cfg_wrap;
            end
        end
    end

`ifdef CA_FIXPOINT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fix_q <= 1'b0;
        end else begin
            fix_q <= fix_d;
        end
    end

    assign fixpoint = fix_q;
`endif

    assign state_out  = gen_q;
    assign step_count = cnt_q;
    assign busy       = (state_q == RUN);
    assign cfg_ready  = (state_q == IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Self-checking bench for wolfram_ca_engine (WIDTH=8): directed cases plus randomized runs vs a reference model.
module tb_wolfram_ca_engine;

    localparam int W = 8;
    localparam int C = 16;

    logic         clk;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [7:0]   cfg_rule;
    logic [W-1:0] cfg_seed;
    logic [C-1:0] cfg_steps;
    logic         cfg_wrap;
    logic [W-1:0] state_out;
    logic [C-1:0] step_count;
    logic         busy;
    logic         done;
`ifdef CA_FIXPOINT_EN
    logic         fixpoint;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]   m_rule;
    logic [W-1:0] m_seed;
    logic [C-1:0] m_steps;
    logic         m_wrap;
    logic [W-1:0] m_final;
    int           m_cnt;

    wolfram_ca_engine #(.WIDTH(W), .CNT_W(C), .DEFAULT_RULE(8'h64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_rule   (cfg_rule),
        .cfg_seed   (cfg_seed),
        .cfg_steps  (cfg_steps),
        .cfg_wrap   (cfg_wrap),
        .state_out  (state_out),
        .step_count (step_count),
        .busy       (busy),
`ifdef CA_FIXPOINT_EN
        .done       (done),
        .fixpoint   (fixpoint)
`else
        .done       (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One generation from the rule table: neighbourhood number = 4*left + 2*centre + right.
    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic [7:0] rule,
                                              input logic wrap);
        logic [W-1:0] r;
        int l, c, rt, idx;
        for (int i = 0; i < W; i++) begin
            if (i == W-1) l = wrap ? int'(s[0]) : 0;
            else          l = int'(s[i+1]);
            if (i == 0)   rt = wrap ? int'(s[W-1]) : 0;
            else          rt = int'(s[i-1]);
            c   = int'(s[i]);
            idx = l * 4 + c * 2 + rt;
            r[i] = (rule >> idx) & 8'd1;
        end
        return r;
    endfunction

    task automatic drive(input logic [7:0] rule, input logic [W-1:0] seed,
                         input logic [C-1:0] steps, input logic wrap);
        int guard = 0;
        @(negedge clk);
        while (!cfg_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", cfg_ready, 1);
        cfg_rule  = rule;
        cfg_seed  = seed;
        cfg_steps = steps;
        cfg_wrap  = wrap;
        cfg_valid = 1'b1;
        m_rule = rule; m_seed = seed; m_steps = steps; m_wrap = wrap;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_rule  = 8'($urandom);
        cfg_seed  = W'($urandom);
        cfg_steps = C'($urandom);
        cfg_wrap  = 1'($urandom);
    endtask

    // Called 1 time unit after the accept edge; returns 1 time unit after the done edge.
    task automatic follow();
        logic [W-1:0] cur, nxt;
        int  n;
        bit  fin, fixed;
        cur = m_seed;
        n   = 0;
        if (m_steps == 0) begin
            chk("zs_done",  done, 1);
            chk("zs_busy",  busy, 0);
            chk("zs_ready", cfg_ready, 1);
            chk("zs_state", state_out, m_seed);
            chk("zs_cnt",   step_count, 0);
            m_final = m_seed;
            m_cnt   = 0;
            return;
        end
        chk("start_busy",  busy, 1);
        chk("start_ready", cfg_ready, 0);
        chk("start_state", state_out, m_seed);
        chk("start_cnt",   step_count, 0);
        fin = 0;
        while (!fin) begin
            @(posedge clk);
            #1;
            nxt = ref_step(cur, m_rule, m_wrap);
            n++;
            fixed = 0;
`ifdef CA_FIXPOINT_EN
            fixed = (nxt == cur);
`endif
            fin = (n == int'(m_steps)) || fixed;
            cur = nxt;
            chk("step_state", state_out, cur);
            chk("step_cnt",   step_count, n);
            chk("step_done",  done, fin);
            chk("step_busy",  busy, !fin);
`ifdef CA_FIXPOINT_EN
            if (fin) chk("fixpoint", fixpoint, fixed);
`endif
        end
        m_final = cur;
        m_cnt   = n;
    endtask

    task automatic after_done();
        @(posedge clk);
        #1;
        chk("post_done",  done, 0);
        chk("post_busy",  busy, 0);
        chk("post_ready", cfg_ready, 1);
        chk("post_state", state_out, m_final);
        chk("post_cnt",   step_count, m_cnt);
    endtask

    task automatic run(input logic [7:0] rule, input logic [W-1:0] seed,
                       input logic [C-1:0] steps, input logic wrap);
        drive(rule, seed, steps, wrap);
        follow();
        after_done();
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_rule = '0; cfg_seed = '0; cfg_steps = '0; cfg_wrap = 1'b0;
        #12;
        chk("rst_state", state_out, 0);
        chk("rst_cnt",   step_count, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived results.
        drive(8'hF0, 8'h01, 1, 1'b1);
        follow();
        chk("ring_shift", state_out, 8'h80);
        after_done();
        drive(8'hF0, 8'h01, 1, 1'b0);
        follow();
        chk("zero_shift", state_out, 8'h00);
        after_done();
        drive(8'h64, 8'h18, 1, 1'b0);
        follow();
        chk("rule_64", state_out, 8'h08);
        after_done();
        drive(8'hCC, 8'hA5, 3, 1'b0);
        follow();
        chk("identity", state_out, 8'hA5);
`ifdef CA_FIXPOINT_EN
        chk("identity_cnt", step_count, 1);
`else
        chk("identity_cnt", step_count, 3);
`endif
        after_done();

        // Zero-step run, then a 5-step run with cfg_valid held for a second config.
        run(8'h5A, 8'h3C, 0, 1'b0);
        drive(8'h96, 8'h81, 5, 1'b1);
        cfg_valid = 1'b1;
        cfg_rule  = 8'hF0;
        cfg_seed  = 8'h42;
        cfg_steps = 2;
        cfg_wrap  = 1'b1;
        follow();
        m_rule = 8'hF0; m_seed = 8'h42; m_steps = 2; m_wrap = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        follow();
        chk("held_result", state_out, 8'h90);
        after_done();

        // Reset during the second step of a 5-step run.
        drive(8'h1E, 8'h10, 5, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", state_out, 0);
        chk("mid_rst_cnt",   step_count, 0);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_done",  done, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", done, 0);
            chk("rst_no_busy", busy, 0);
        end

        // Randomized runs.
        for (int t = 0; t < 40; t++) begin
            run(8'($urandom), W'($urandom), C'($urandom_range(0, 10)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
